// File: rtl/sort_pkg.sv
// Shared types and constants for the sequential 4-input sorter.
// Holds the FSM state enum, the compare-exchange step table and the default data width.
package sort_pkg;

    localparam int unsigned DefaultW = 6;
    localparam int unsigned NumSteps = 5;
    localparam logic [2:0]  LastStep = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Index pairs {i, j} visited in step order; together they form a 4-input sorting network
    localparam logic [3:0] StepPairs [NumSteps] = '{
        {2'd0, 2'd1},
        {2'd2, 2'd3},
        {2'd0, 2'd2},
        {2'd1, 2'd3},
        {2'd1, 2'd2}
    };

    // Table lookup with a safe fallback for unused step codes
    function automatic logic [3:0] step_pair(input logic [2:0] step);
        logic [3:0] pair;
        pair = {2'd0, 2'd1};
        if (step <= LastStep) begin
            pair = StepPairs[step];
        end
        return pair;
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Single compare-exchange cell: orders two unsigned operands.
// Equal operands are never flagged as swapped.
module cmp_swap #(
    parameter int unsigned w = sort_pkg::DefaultW
) (
    input  logic [w-1:0] x,
    input  logic [w-1:0] y,
    output logic [w-1:0] lo,
    output logic [w-1:0] hi,
    output logic         swapped
);

    // Strict greater-than keeps equal values in place
    always_comb begin
        swapped = (x > y);
        lo      = swapped ? y : x;
        hi      = swapped ? x : y;
    end

endmodule

// File: rtl/sort4_seq.sv
// Sequential 4-operand sorter: one compare-exchange per cycle through a single shared
// comparator, five steps per sort, results held until the next completed sort.
// Optional feature: define SORT4_SEQ_SWAPCNT_EN to add the 'swaps' exchange-count output.
module sort4_seq
    import sort_pkg::*;
#(
    parameter int unsigned w = DefaultW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    input  logic [w-1:0] c,
    input  logic [w-1:0] d,
    output logic         busy,
    output logic         done,
    output logic [w-1:0] min,
    output logic [w-1:0] midl,
    output logic [w-1:0] midh,
`ifdef SORT4_SEQ_SWAPCNT_EN
    output logic [2:0]   swaps,
`endif
    output logic [w-1:0] max
);

    state_e       r_state;
    state_e       w_state_nxt;
    logic [2:0]   r_step;
    logic [w-1:0] r_data [4];
    logic [w-1:0] w_data_nxt [4];
    logic [w-1:0] r_min;
    logic [w-1:0] r_midl;
    logic [w-1:0] r_midh;
    logic [w-1:0] r_max;

    logic [3:0]   w_pair;
    logic [1:0]   w_idx_i;
    logic [1:0]   w_idx_j;
    logic [w-1:0] w_x;
    logic [w-1:0] w_y;
    logic [w-1:0] w_lo;
    logic [w-1:0] w_hi;
    logic         w_swapped;
    logic         w_last;

    assign w_pair  = step_pair(r_step);
    assign w_idx_i = w_pair[3:2];
    assign w_idx_j = w_pair[1:0];
    assign w_x     = r_data[w_idx_i];
    assign w_y     = r_data[w_idx_j];
    assign w_last  = (r_step == LastStep);

    cmp_swap #(
        .w (w)
    ) u_cmp_swap (
        .x       (w_x),
        .y       (w_y),
        .lo      (w_lo),
        .hi      (w_hi),
        .swapped (w_swapped)
    );

    // Working set after this cycle's exchange; only the selected pair is rewritten
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_data_nxt[k] = r_data[k];
        end
        if (w_swapped) begin
            w_data_nxt[w_idx_i] = w_lo;
            w_data_nxt[w_idx_j] = w_hi;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and status outputs; start is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                done        = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Operand capture, step sequencing and result write-back on the final step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
            r_min  <= '0;
            r_midl <= '0;
            r_midh <= '0;
            r_max  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_data[0] <= a;
                        r_data[1] <= b;
                        r_data[2] <= c;
                        r_data[3] <= d;
                        r_step    <= 3'd0;
                    end
                end
                StRun: begin
                    for (int k = 0; k < 4; k++) begin
                        r_data[k] <= w_data_nxt[k];
                    end
                    if (w_last) begin
                        r_step <= 3'd0;
                        r_min  <= w_data_nxt[0];
                        r_midl <= w_data_nxt[1];
                        r_midh <= w_data_nxt[2];
                        r_max  <= w_data_nxt[3];
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign min  = r_min;
    assign midl = r_midl;
    assign midh = r_midh;
    assign max  = r_max;

`ifdef SORT4_SEQ_SWAPCNT_EN
    logic [2:0] r_swap_cnt;
    logic [2:0] r_swaps;
    logic [2:0] w_swap_cnt_nxt;

    assign w_swap_cnt_nxt = r_swap_cnt + {2'b00, w_swapped};

    // Exchange counter for the sort in flight; published alongside the results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_swap_cnt <= 3'd0;
            r_swaps    <= 3'd0;
        end else if (r_state == StIdle && start) begin
            r_swap_cnt <= 3'd0;
        end else if (r_state == StRun) begin
            r_swap_cnt <= w_swap_cnt_nxt;
            if (w_last) begin
                r_swaps <= w_swap_cnt_nxt;
            end
        end
    end

    assign swaps = r_swaps;
`endif

endmodule

// File: tb/tb_sort4_seq.sv
// Directed self-checking bench for sort4_seq (covers the SORT4_SEQ_SWAPCNT_EN build too).
module tb_sort4_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] a, b, c, d;
    logic       busy, done;
    logic [5:0] min, midl, midh, max;
`ifdef SORT4_SEQ_SWAPCNT_EN
    logic [2:0] swaps;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Results the bench expects the DUT to be holding
    logic [5:0] last_min, last_midl, last_midh, last_max;

    sort4_seq #(
        .w (6)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .busy  (busy),
        .done  (done),
        .min   (min),
        .midl  (midl),
        .midh  (midh),
`ifdef SORT4_SEQ_SWAPCNT_EN
        .swaps (swaps),
`endif
        .max   (max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is 1 time unit after an edge with the DUT in IDLE
    task automatic do_sort(input logic [5:0] ia, input logic [5:0] ib, input logic [5:0] ic,
                           input logic [5:0] id, input logic [5:0] emin, input logic [5:0] emidl,
                           input logic [5:0] emidh, input logic [5:0] emax,
                           input logic [2:0] eswaps);
        int lat;
        int nbusy;
        a = ia; b = ib; c = ic; d = id;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Operand changes after the accept edge must not matter
        a = ~ia; b = ~ib; c = ~ic; d = ~id;
        lat = 0;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            check_eq("hold_outputs", 32'({min, midl, midh, max}),
                     32'({last_min, last_midl, last_midh, last_max}));
            tick();
            lat++;
        end
        check_eq("latency", 32'(lat), 32'd5);
        check_eq("busy_cycles", 32'(nbusy), 32'd5);
        check_eq("busy_in_done", 32'(busy), 32'd0);
        check_eq("min", 32'(min), 32'(emin));
        check_eq("midl", 32'(midl), 32'(emidl));
        check_eq("midh", 32'(midh), 32'(emidh));
        check_eq("max", 32'(max), 32'(emax));
`ifdef SORT4_SEQ_SWAPCNT_EN
        check_eq("swaps", 32'(swaps), 32'(eswaps));
`else
        if (eswaps > 3'd5) $display("note: unexpected swap count %0d", eswaps);
`endif
        last_min = emin; last_midl = emidl; last_midh = emidh; last_max = emax;
        tick();
        check_eq("done_pulse_len", 32'(done), 32'd0);
        check_eq("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_done;
        int   t0;
        rst = 1'b0; start = 1'b0;
        a = 6'd0; b = 6'd0; c = 6'd0; d = 6'd0;
        last_min = 6'd0; last_midl = 6'd0; last_midh = 6'd0; last_max = 6'd0;
        #12;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_outputs", 32'({min, midl, midh, max}), 32'd0);
`ifdef SORT4_SEQ_SWAPCNT_EN
        check_eq("rst_swaps", 32'(swaps), 32'd0);
`endif
        tick();
        rst = 1'b1;
        tick();

        do_sort(6'd5, 6'd3, 6'd9, 6'd1, 6'd1, 6'd3, 6'd5, 6'd9, 3'd4);
        do_sort(6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 3'd0);
        do_sort(6'd63, 6'd42, 6'd21, 6'd0, 6'd0, 6'd21, 6'd42, 6'd63, 3'd4);

        // start held high with operands changing every cycle: {t+3, t+1, t+2, t}
        start = 1'b1;
        a = 6'd3; b = 6'd1; c = 6'd2; d = 6'd0;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            tick();
            exp_done = (cyc == 6) || (cyc == 13) || (cyc == 20);
            check_eq("held_done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                t0 = cyc - 6;
                check_eq("held_min", 32'(min), 32'(t0));
                check_eq("held_midl", 32'(midl), 32'(t0 + 1));
                check_eq("held_midh", 32'(midh), 32'(t0 + 2));
                check_eq("held_max", 32'(max), 32'(t0 + 3));
`ifdef SORT4_SEQ_SWAPCNT_EN
                check_eq("held_swaps", 32'(swaps), 32'd5);
`endif
            end
            a = 6'(cyc + 3); b = 6'(cyc + 1); c = 6'(cyc + 2); d = 6'(cyc);
        end
        start = 1'b0;
        last_min = 6'd14; last_midl = 6'd15; last_midh = 6'd16; last_max = 6'd17;
        tick();
        check_eq("held_idle_busy", 32'(busy), 32'd0);

        // Abort a sort at step 2 with reset
        a = 6'd9; b = 6'd8; c = 6'd7; d = 6'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_outputs", 32'({min, midl, midh, max}), 32'd0);
`ifdef SORT4_SEQ_SWAPCNT_EN
        check_eq("abort_swaps", 32'(swaps), 32'd0);
`endif
        last_min = 6'd0; last_midl = 6'd0; last_midh = 6'd0; last_max = 6'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("abort_no_done", 32'(done), 32'd0);
        end
        rst = 1'b1;
        do_sort(6'd10, 6'd20, 6'd30, 6'd40, 6'd10, 6'd20, 6'd30, 6'd40, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
